// File: rtl/sr_cmd_gen.sv
// +----------------------------------------------------------------------------+
// | sr_cmd_gen: synchronises, debounces and arbitrates raw set/reset requests  |
// | into mutually exclusive single-cycle S/R pulses for a downstream SR flop.  |
// | Optional statistics counters enabled by macro SR_CMD_STATS_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sr_cmd_gen #(
  parameter int DB_CYCLES      = 4,
  parameter int HOLD_CYCLES    = 3,
  parameter int RESET_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       reset_in,
  output logic       S,
  output logic       R,
  output logic       busy
`ifdef SR_CMD_STATS_EN
  ,
  output logic [7:0] conflict_cnt,
  output logic [7:0] drop_cnt
`endif
);

  localparam int               c_cnt_w     = $clog2(DB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [7:0]       c_hold      = 8'(HOLD_CYCLES);
  localparam bit               c_rst_wins  = (RESET_PRIORITY != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_req;
  logic       w_set_req;
  logic       w_rst_req;

  assign w_raw = {reset_in, set_in};

  // Channel 0 is set, channel 1 is reset.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_db
      logic               r_meta;
      logic               r_sync;
      logic               r_stable;
      logic               r_stable_q;
      logic [c_cnt_w-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_meta     <= 1'b0;
          r_sync     <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_q <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_meta     <= w_raw[g];
          r_sync     <= r_meta;
          r_stable_q <= r_stable;
          if (r_sync == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_db_last) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
      end

      assign w_req[g] = r_stable & ~r_stable_q;
    end
  endgenerate

  assign w_set_req = w_req[0];
  assign w_rst_req = w_req[1];

  state_t     r_state;
  logic [7:0] r_hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= 8'd0;
      S          <= 1'b0;
      R          <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_set_req || w_rst_req) begin
            r_state <= PULSE;
            busy    <= 1'b1;
            // Simultaneous requests: only the priority winner is pulsed.
            if (w_set_req && w_rst_req) begin
              S <= ~c_rst_wins;
              R <= c_rst_wins;
            end else begin
              S <= w_set_req;
              R <= w_rst_req;
            end
          end
        end
        PULSE: begin
          S <= 1'b0;
          R <= 1'b0;
          if (c_hold == 8'd0) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_state    <= HOLD;
            r_hold_cnt <= c_hold;
          end
        end
        HOLD: begin
          if (r_hold_cnt == 8'd1) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          S       <= 1'b0;
          R       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SR_CMD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 8'd0;
      drop_cnt     <= 8'd0;
    end else begin
      if (r_state == IDLE && w_set_req && w_rst_req && conflict_cnt != 8'hFF)
        conflict_cnt <= conflict_cnt + 8'd1;
      if (r_state != IDLE && (w_set_req || w_rst_req) && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
// +----------------------------------------------------------------------------+
// | tb_sr_cmd_gen: directed self-checking bench for sr_cmd_gen (defaults plus  |
// | a set-priority instance). Revision: 1.0                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_in = 1'b0;
  logic reset_in = 1'b0;
  logic s1, r1, busy1;
  logic s0, r0, busy0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef SR_CMD_STATS_EN
  logic [7:0] conf1, drop1, conf0, drop0;
`endif

  always #5 clk = ~clk;

  sr_cmd_gen #(.DB_CYCLES(4), .HOLD_CYCLES(3), .RESET_PRIORITY(1)) dut (
    .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
    .S(s1), .R(r1), .busy(busy1)
`ifdef SR_CMD_STATS_EN
    , .conflict_cnt(conf1), .drop_cnt(drop1)
`endif
  );

  sr_cmd_gen #(.DB_CYCLES(4), .HOLD_CYCLES(3), .RESET_PRIORITY(0)) dut_sp (
    .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
    .S(s0), .R(r0), .busy(busy0)
`ifdef SR_CMD_STATS_EN
    , .conflict_cnt(conf0), .drop_cnt(drop0)
`endif
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    vectors++;
    if ({s1, r1, busy1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: S/R/busy=%b required 000", {s1, r1, busy1});
    end
`ifdef SR_CMD_STATS_EN
    vectors++;
    if (conf1 !== 8'd0 || drop1 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counters: conflict=%0d drop=%0d required 0/0", conf1, drop1);
    end
`endif
    rst = 1'b0;
    set_in = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    vectors++;
    if (s1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prepulse: S=%b required 1", s1);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({s1, r1, busy1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_async: S/R/busy=%b required 000 before any edge", {s1, r1, busy1});
    end
`ifdef SR_CMD_STATS_EN
    vectors++;
    if (conf1 !== 8'd0 || drop1 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_async_counters: conflict=%0d drop=%0d required 0/0", conf1, drop1);
    end
`endif
    idle(2);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 5 || k == 6) begin
        vectors++;
        if (s1 !== (k == 6)) begin
          miscompares++;
          $display("FAIL reset_rerelease_edge%0d: S=%b required %b", k, s1, (k == 6));
        end
      end
    end
    set_in = 1'b0;
    idle(15);
  endtask

  task automatic test_clean_set();
    int bad_s = 0, bad_r = 0, bad_b = 0;
    set_in = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      step();
      if (s1 !== (k == 6)) bad_s++;
      if (r1 !== 1'b0) bad_r++;
      if (busy1 !== (k >= 6 && k <= 9)) bad_b++;
      if (k == 6 || k == 7) begin
        vectors++;
        if (s1 !== (k == 6)) begin
          miscompares++;
          $display("FAIL clean_set_S_edge%0d: S=%b required %b", k, s1, (k == 6));
        end
      end
      if (k == 9 || k == 10) begin
        vectors++;
        if (busy1 !== (k == 9)) begin
          miscompares++;
          $display("FAIL clean_set_busy_edge%0d: busy=%b required %b", k, busy1, (k == 9));
        end
      end
    end
    vectors++;
    if (bad_s != 0 || bad_r != 0 || bad_b != 0) begin
      miscompares++;
      $display("FAIL clean_set_profile: bad S=%0d R=%0d busy=%0d cycles required 0", bad_s, bad_r, bad_b);
    end
    set_in = 1'b0;
    idle(15);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (k < 10) set_in = ~set_in;
      else        set_in = 1'b0;
      step();
      if (s1 || r1 || s0 || r0 || busy1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL bounce: %0d active cycles required 0", pulses);
    end
    // A clean press afterwards must still take the full latency, proving stable stayed low.
    set_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k >= 5) begin
        vectors++;
        if (s1 !== (k == 6)) begin
          miscompares++;
          $display("FAIL bounce_followup_edge%0d: S=%b required %b", k, s1, (k == 6));
        end
      end
    end
    set_in = 1'b0;
    idle(15);
  endtask

  task automatic test_simultaneous();
    int s1n = 0, r1n = 0, s0n = 0, r0n = 0;
    set_in = 1'b1;
    reset_in = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      s1n += int'(s1);
      r1n += int'(r1);
      s0n += int'(s0);
      r0n += int'(r0);
    end
    vectors++;
    if (s1n != 0 || r1n != 1) begin
      miscompares++;
      $display("FAIL simul_rp1: S pulses=%0d R pulses=%0d required 0/1", s1n, r1n);
    end
    vectors++;
    if (s0n != 1 || r0n != 0) begin
      miscompares++;
      $display("FAIL simul_rp0: S pulses=%0d R pulses=%0d required 1/0", s0n, r0n);
    end
`ifdef SR_CMD_STATS_EN
    vectors++;
    if (conf1 !== 8'd1 || drop1 !== 8'd0 || conf0 !== 8'd1) begin
      miscompares++;
      $display("FAIL simul_counts: conflict=%0d drop=%0d conflict_sp=%0d required 1/0/1", conf1, drop1, conf0);
    end
`endif
    set_in = 1'b0;
    reset_in = 1'b0;
    idle(15);
  endtask

  task automatic test_lockout_drop();
    int rn = 0;
    set_in = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      // reset_in first sampled at edge 3, so its request lands at edge 9 during HOLD.
      if (k == 2) reset_in = 1'b1;
      rn += int'(r1);
    end
    vectors++;
    if (rn != 0) begin
      miscompares++;
      $display("FAIL lockout_drop: R pulses=%0d required 0", rn);
    end
`ifdef SR_CMD_STATS_EN
    vectors++;
    if (drop1 !== 8'd1) begin
      miscompares++;
      $display("FAIL lockout_drop_cnt: drop=%0d required 1", drop1);
    end
`endif
    set_in = 1'b0;
    reset_in = 1'b0;
    idle(15);
    reset_in = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k >= 5) begin
        vectors++;
        if (r1 !== (k == 6) || s1 !== 1'b0) begin
          miscompares++;
          $display("FAIL lockout_retry_edge%0d: R=%b S=%b required %b/0", k, r1, s1, (k == 6));
        end
      end
    end
    reset_in = 1'b0;
    idle(15);
  endtask

`ifdef SR_CMD_STATS_EN
  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      set_in = 1'b1;
      reset_in = 1'b1;
      idle(12);
      set_in = 1'b0;
      reset_in = 1'b0;
      idle(8);
    end
    vectors++;
    if (conf1 !== 8'd255 || conf0 !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: conflict=%0d conflict_sp=%0d required 255/255", conf1, conf0);
    end
  endtask
`endif

  int overlap = 0;
  always @(negedge clk) if ((s1 & r1) || (s0 & r0)) overlap++;

  initial begin
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_lockout_drop();
`ifdef SR_CMD_STATS_EN
    test_saturation();
`endif
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL sr_exclusive: %0d cycles with S&R required 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the SR flip-flop (`sr_ff`). It takes two raw, possibly bouncing set/reset request lines and synchronises and debounces each one. It then arbitrates between them and drives clean, single-cycle `S`/`R` pulses into the flop. `S` and `R` are never high together, so the forbidden S=R=1 input of the downstream flop can never occur.

## Interface
Parameters:
- `DB_CYCLES`, 4: consecutive synchronised samples required to accept a level change; legal range 1..255.
- `HOLD_CYCLES`, 3: lockout cycles after each output pulse; legal range 0..255.
- `RESET_PRIORITY`, 1: tie-break rule. 1 means reset wins a simultaneous request; 0 means set wins.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `set_in`  in  1  raw set request; asynchronous and may bounce.
- `reset_in`  in  1  raw reset request; asynchronous and may bounce.
- `S`  out  1  set pulse to `sr_ff.S`; registered.
- `R`  out  1  reset pulse to `sr_ff.R`; registered.
- `busy`  out  1  high in PULSE and HOLD states; registered.
- `conflict_cnt`  out  8  simultaneous-request count. Present only with `SR_CMD_STATS_EN`.
- `drop_cnt`  out  8  dropped-request count. Present only with `SR_CMD_STATS_EN`.

## Operation
- **Synchroniser.** Each raw input passes through its own 2-flop synchroniser.
- **Debounce, per channel.**
  - The debouncer holds a `stable` bit and a counter of width clog2(DB_CYCLES+1).
  - When the synchronised sample equals `stable`, the counter clears.
  - Otherwise the counter increments. On the edge where it reaches DB_CYCLES, `stable` toggles and the counter clears.
- **Request.** A request is the one-cycle rising edge of `stable`. Falling edges generate nothing.
- **FSM.** States are IDLE, PULSE, HOLD.
  - IDLE, one request pending: go to PULSE and register S=1 (set request) or R=1 (reset request).
  - IDLE, both requests in the same cycle: the `RESET_PRIORITY` winner is pulsed and the loser is discarded. This counts as one conflict and no drop.
  - PULSE lasts exactly 1 cycle. It then goes to HOLD, or to IDLE directly if HOLD_CYCLES=0. S and R clear on leaving PULSE.
  - HOLD lasts exactly HOLD_CYCLES cycles, counted down by an 8-bit down-counter, then returns to IDLE.
  - Any request arriving in PULSE or HOLD is discarded and counted as a drop; if both arrive in the same cycle, that is one drop. Debouncers keep tracking levels regardless of FSM state.
- **Held input.** A level held high produces exactly one pulse. A new pulse needs a debounced release and a debounced re-press.
- **Reset values.** `rst` clears synchronisers, `stable`=0, counters=0, FSM=IDLE, S=0, R=0, busy=0, and both statistics counters to 0.
  - Reset asserted mid-pulse clears S/R immediately, without waiting for the clock.
  - If an input is still high after reset releases, it is treated as a new press and pulses after the full latency.

## Timing
- Let `set_in` be first sampled high at edge 0 and held.
  - sync2 goes high at edge 1.
  - `stable` toggles at edge DB_CYCLES+1.
  - S rises at edge DB_CYCLES+2 and falls at edge DB_CYCLES+3.
  - `busy` rises with S and falls at edge DB_CYCLES+3+HOLD_CYCLES.
- With defaults (DB_CYCLES=4, HOLD_CYCLES=3): S is high during edges 6..7, and `busy` is high during edges 6..10.
- **Glitches.** An input pulse shorter than DB_CYCLES synchronised cycles produces no output and leaves `stable` unchanged.
- **Earliest repeat.** The next request is accepted in the cycle where `busy`=0, i.e. on edge DB_CYCLES+3+HOLD_CYCLES or later.
- **Invariant.** S&R=0 in every cycle, including during and after reset.

## Configuration
- `SR_CMD_STATS_EN` defined:
  - `conflict_cnt` and `drop_cnt` ports and registers exist.
  - Each is an 8-bit counter that saturates at 255 (no wrap) and is cleared only by `rst`.
- `SR_CMD_STATS_EN` undefined:
  - Both ports and registers are removed.
  - S/R/busy behaviour is identical.

## Test plan
- **Reset.** Assert `rst` mid-pulse (S=1) -> S=0 immediately, without a clock edge; busy=0; counters=0. Keep `set_in`=1 through reset release at edge 0 -> S rises again at edge 6.
- **Clean set.** DB=4, HOLD=3: `set_in` 0->1 sampled at edge 0 and held -> S=1 for edges 6..7 only, R=0 throughout, busy=1 for edges 6..10, no second pulse while held.
- **Bounce.** `set_in` toggles every cycle for 10 cycles, then settles at 0 -> S and R stay 0; `stable` is never set.
- **Simultaneous requests.** `set_in` and `reset_in` rise on the same edge, RESET_PRIORITY=1 -> single R pulse, no S pulse, conflict_cnt=1. Repeat with RESET_PRIORITY=0 -> S pulse only.
- **Lockout drop.** A debounced `reset_in` request lands while busy=1 after a set pulse -> no R pulse, drop_cnt increments by 1. The same request arriving after busy=0 -> R pulse.
- **Saturation.** With `SR_CMD_STATS_EN`, generate 300 conflicts -> conflict_cnt holds 255. Without the macro, the bench compiles with no statistics ports.
